// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ctrl
//  Description : Fetch-address register for the pipelined MIPS core. Selects
//                between exception entry, ERET return, branch/jump redirect,
//                a buffered redirect captured during a stall, and sequential
//                pc + 4. Also registers the fetch address-error flag (AdEL).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_HI   = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_adel,
  output logic             redirect_pending
);

  // Address-error flag for the reset vector, resolved at elaboration.
  localparam logic c_reset_adel = (RESET_VEC[1:0] != 2'b00) ||
                                  (RESET_VEC < IMEM_LO)     ||
                                  (RESET_VEC > IMEM_HI);

  localparam logic [WIDTH-1:0] c_four = WIDTH'(4);

  // Misaligned or outside the instruction memory window (unsigned compare).
  function automatic logic fault(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction

  logic [WIDTH-1:0] r_pc;
  logic             r_adel;
  logic             r_pending;
  logic [WIDTH-1:0] r_buf;

  logic [WIDTH-1:0] w_pc_next;
  logic             w_load;
  logic             w_pending_next;
  logic [WIDTH-1:0] w_buf_next;
  logic [WIDTH-1:0] w_pc_plus4;

  // Sequential successor; wraps naturally modulo 2^WIDTH.
  assign w_pc_plus4 = r_pc + c_four;

  // Priority select of the next fetch address and pending-buffer update.
  always_comb begin
    w_pc_next      = r_pc;
    w_load         = 1'b0;
    w_pending_next = r_pending;
    w_buf_next     = r_buf;
    if (exc_req) begin
      // Exception entry beats ERET and ignores the stall.
      w_pc_next      = EXC_VEC;
      w_load         = 1'b1;
      w_pending_next = 1'b0;
    end else if (eret_req) begin
      w_pc_next      = epc;
      w_load         = 1'b1;
      w_pending_next = 1'b0;
    end else if (en) begin
      w_load         = 1'b1;
      w_pending_next = 1'b0;
      if (redirect_valid) begin
        // A fresh redirect supersedes anything buffered.
        w_pc_next = redirect_target;
      end else if (r_pending) begin
        w_pc_next = r_buf;
      end else begin
        w_pc_next = w_pc_plus4;
      end
    end else if (redirect_valid) begin
      // Stalled: remember the redirect until the pipe moves (last one wins).
      w_buf_next     = redirect_target;
      w_pending_next = 1'b1;
    end
  end

  // PC, AdEL flag and redirect buffer registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_VEC;
      r_adel    <= c_reset_adel;
      r_pending <= 1'b0;
      r_buf     <= '0;
    end else begin
      r_pc      <= w_pc_next;
      r_pending <= w_pending_next;
      r_buf     <= w_buf_next;
      if (w_load) begin
        r_adel <= fault(w_pc_next);
      end
    end
  end

  assign pc               = r_pc;
  assign pc_plus4         = w_pc_plus4;
  assign fetch_adel       = r_adel;
  assign redirect_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_ctrl
//  Description : Directed self-checking bench for pc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_adel;
  logic        redirect_pending;

  int n_cmp = 0;
  int n_err = 0;

  pc_ctrl #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .IMEM_LO  (32'h0000_3000),
    .IMEM_HI  (32'h0000_6FFC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_adel      (fetch_adel),
    .redirect_pending(redirect_pending)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare full visible state after an edge.
  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic e_adel, input logic e_pend);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".adel"}, {31'd0, fetch_adel}, {31'd0, e_adel});
    chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, e_pend});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    // Reset for two cycles.
    step(); step();
    chk_all("reset", 32'h3000, 1'b0, 1'b0);

    // Sequential run.
    reset = 1'b0; en = 1'b1;
    step(); chk_all("seq1", 32'h3004, 1'b0, 1'b0);
    step(); chk_all("seq2", 32'h3008, 1'b0, 1'b0);
    step(); chk_all("seq3", 32'h300C, 1'b0, 1'b0);
    step(); chk_all("seq4", 32'h3010, 1'b0, 1'b0);

    // Stall with buffered redirect, then release.
    en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3400;
    step(); chk_all("stall_buf", 32'h3010, 1'b0, 1'b1);
    en = 1'b1; redirect_valid = 1'b0;
    step(); chk_all("buf_release", 32'h3400, 1'b0, 1'b0);

    // Exception overrides stall and pending buffer.
    en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3400;
    step(); chk_all("pend_again", 32'h3400, 1'b0, 1'b1);
    redirect_valid = 1'b0; exc_req = 1'b1;
    step(); chk_all("exc", 32'h4180, 1'b0, 1'b0);
    eret_req = 1'b1; epc = 32'h3020;
    step(); chk_all("exc_over_eret", 32'h4180, 1'b0, 1'b0);
    exc_req = 1'b0;

    // ERET return, aligned then misaligned.
    epc = 32'h3024;
    step(); chk_all("eret", 32'h3024, 1'b0, 1'b0);
    epc = 32'h3022;
    step(); chk_all("eret_misal", 32'h3022, 1'b1, 1'b0);
    eret_req = 1'b0;

    // Hold keeps pc and flag.
    step(); chk_all("hold", 32'h3022, 1'b1, 1'b0);

    // Range boundaries and wrap.
    en = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h7000;
    step(); chk_all("above_hi", 32'h7000, 1'b1, 1'b0);
    redirect_target = 32'h6FFC;
    step(); chk_all("at_hi", 32'h6FFC, 1'b0, 1'b0);
    redirect_target = 32'h2FFC;
    step(); chk_all("below_lo", 32'h2FFC, 1'b1, 1'b0);
    redirect_target = 32'hFFFF_FFFC;
    step(); chk_all("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_all("wrap", 32'h0000_0000, 1'b1, 1'b0);

    // New redirect beats buffered one.
    en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3100;
    step(); chk_all("buf_3100", 32'h0000_0000, 1'b1, 1'b1);
    en = 1'b1; redirect_target = 32'h3200;
    step(); chk_all("new_wins", 32'h3200, 1'b0, 1'b0);

    // Last buffered redirect wins.
    en = 1'b0; redirect_target = 32'h3300;
    step();
    redirect_target = 32'h3304;
    step(); chk_all("buf_last", 32'h3200, 1'b0, 1'b1);
    en = 1'b1; redirect_valid = 1'b0;
    step(); chk_all("last_wins", 32'h3304, 1'b0, 1'b0);

    // Reset mid-operation with pending and exception asserted.
    en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3500;
    step(); chk_all("pre_reset", 32'h3304, 1'b0, 1'b1);
    reset = 1'b1; exc_req = 1'b1; en = 1'b1;
    step(); chk_all("reset_mid", 32'h3000, 1'b0, 1'b0);
    reset = 1'b0; exc_req = 1'b0; redirect_valid = 1'b0;
    step(); chk_all("post_reset", 32'h3004, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
